load_store_unit: RTL and testbench

- Memory stage directly downstream of the ALU in the RV32I datapath.
- Takes ALUResult as the effective address and turns load/store instructions into a req/ack transaction on the data-memory bus.
- Applies RV32I byte/halfword lane steering and load sign/zero extension.
- Stalls the pipeline until the access completes.

---
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns EX-stage loads/stores into a req/ack data-memory transaction.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned halfword/word accesses without touching memory.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  stall_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
`endif

    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [31:0]             r_waitCnt;
    logic [2:0]              r_f3;
    logic [1:0]              r_lane;
    logic                    r_memReq;
    logic                    r_memWe;
    logic [DATA_WIDTH-1:0]   r_memAddr;
    logic [3:0]              r_memBe;
    logic [DATA_WIDTH-1:0]   r_memWdata;
    logic                    r_done;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_readData;

    logic                    w_accept;
    logic                    w_timeout;
    logic [3:0]              w_be;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_loadData;

    assign w_accept  = (r_state == S_IDLE) && valid_i && (MemRead || MemWrite);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_waitCnt == TIMEOUT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                          (Funct3[1] && (ALUResult[1:0] != 2'b00));
`endif

    // Store lane steering; stray low address bits of a halfword/word are simply dropped here
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = '0;
        if (MemWrite) begin
            w_wdata = WriteData;
            case (Funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << ALUResult[1:0];
                    w_wdata = {4{WriteData[7:0]}};
                end
                2'b01: begin
                    w_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{WriteData[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_lane)
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        // Funct3[2] selects zero extension (LBU/LHU)
        case (r_f3[1:0])
            2'b00:   w_loadData = {{24{w_byte[7] & ~r_f3[2]}}, w_byte};
            2'b01:   w_loadData = {{16{w_half[15] & ~r_f3[2]}}, w_half};
            default: w_loadData = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        stall_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stall_o = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                    w_nextState = w_misaligned ? S_ERR : S_REQ;
`else
                    w_nextState = S_REQ;
`endif
                end
            end
            S_REQ: begin
                stall_o = 1'b1;
                if (mem_ack || w_timeout) w_nextState = S_RESP;
            end
            S_RESP: w_nextState = S_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
            S_ERR:  w_nextState = S_RESP;
`endif
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_waitCnt  <= '0;
            r_f3       <= '0;
            r_lane     <= '0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memBe    <= '0;
            r_memWdata <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_readData <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_memAddr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        r_memBe    <= w_be;
                        r_memWdata <= w_wdata;
                        r_memWe    <= MemWrite;
                        r_f3       <= Funct3;
                        r_lane     <= ALUResult[1:0];
                        r_waitCnt  <= '0;
                        r_memReq   <= (w_nextState == S_REQ);
                    end
                end
                S_REQ: begin
                    r_waitCnt <= r_waitCnt + 32'd1;
                    // An ack in the final timeout cycle still completes normally
                    if (mem_ack) begin
                        r_memReq   <= 1'b0;
                        r_done     <= 1'b1;
                        r_readData <= r_memWe ? '0 : w_loadData;
                    end else if (w_timeout) begin
                        r_memReq   <= 1'b0;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_readData <= '0;
                    end
                end
`ifdef LSU_MISALIGN_TRAP_EN
                S_ERR: begin
                    r_done     <= 1'b1;
                    r_err      <= 1'b1;
                    r_readData <= '0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign mem_req   = r_memReq;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_be    = r_memBe;
    assign mem_wdata = r_memWdata;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign ReadData  = r_readData;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, reset/timeout/wait sequences and
// random transactions compared against a byte-level model of RV32I load/store rules.
module tb_load_store_unit;

    localparam int TO = 8;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, valid_i, MemRead, MemWrite, mem_ack;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData, mem_rdata;
    logic        stall_o, done_o, err_o, mem_req, mem_we;
    logic [31:0] ReadData, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int nVec = 0;
    int nMis = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRd;
        logic        expErr;
        int          expLat;
    } vec_t;

    typedef struct {
        int          lat;
        int          req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rd;
        logic        err;
        logic        stable;
        logic        stallOk;
        logic        pulseOk;
    } obs_t;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData), .stall_o(stall_o),
        .done_o(done_o), .err_o(err_o), .ReadData(ReadData), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    // Reference model: access size in bytes, effective lane offset, and extension by arithmetic
    function automatic int sizeOf(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit isMis(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr[1:0]) % sizeOf(f3)) != 0;
    endfunction

    function automatic int offOf(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr[1:0]) / sizeOf(f3)) * sizeOf(f3);
    endfunction

    function automatic logic [3:0] modelBe(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        int m;
        if (!wr) return 4'hF;
        m = ((1 << sizeOf(f3)) - 1) << offOf(f3, addr);
        return m[3:0];
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sizeOf(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        longint v;
        int sz;
        sz = sizeOf(f3);
        v  = {32'd0, rdata};
        v  = (v >> (8 * offOf(f3, addr))) & ((longint'(1) << (8 * sz)) - 1);
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    function automatic vec_t mkVec(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata, input int delay,
                                   input logic [31:0] expAddr, input logic [3:0] expBe,
                                   input logic [31:0] expWdata, input logic [31:0] expRd,
                                   input logic expErr, input int expLat);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.delay = delay;
        v.expAddr = expAddr; v.expBe = expBe; v.expWdata = expWdata; v.expRd = expRd;
        v.expErr = expErr; v.expLat = expLat;
        return v;
    endfunction

    function automatic vec_t modelVec(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
        vec_t v;
        bit tmo;
        tmo = (delay < 0) || (delay >= TO);
        v = mkVec(wr, f3, addr, wdata, rdata, delay, {addr[31:2], 2'b00}, modelBe(wr, f3, addr),
                  modelWdata(f3, wdata), 32'd0, 1'b0, 2 + delay);
        if (TRAP && isMis(f3, addr)) begin
            v.expErr = 1'b1; v.expLat = 2;
        end else if (tmo) begin
            v.expErr = 1'b1; v.expLat = TO + 1;
        end else if (!wr) begin
            v.expRd = modelLoad(f3, addr, rdata);
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit noise, output obs_t o);
        int cyc;
        int k;
        o.lat = 0; o.req = 0; o.addr = '0; o.be = '0; o.wdata = '0; o.we = 1'b0;
        o.rd = '0; o.err = 1'b0; o.stable = 1'b1; o.stallOk = 1'b1; o.pulseOk = 1'b1;
        @(negedge clk);
        valid_i = 1'b1; MemRead = !v.wr; MemWrite = v.wr; Funct3 = v.f3;
        ALUResult = v.addr; WriteData = v.wdata; mem_ack = 1'b0;
        #1;
        if (stall_o !== 1'b1) o.stallOk = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        cyc = 0;
        k = 0;
        while (done_o !== 1'b1 && cyc < 40) begin
            if (mem_req === 1'b1) begin
                if (k == 0) begin
                    o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.we = mem_we;
                end else if (mem_addr !== o.addr || mem_be !== o.be ||
                             mem_wdata !== o.wdata || mem_we !== o.we) begin
                    o.stable = 1'b0;
                end
                if (stall_o !== 1'b1) o.stallOk = 1'b0;
                mem_ack   = (k == v.delay);
                mem_rdata = mem_ack ? v.rdata : $urandom;
                if (noise) begin
                    valid_i = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_0F00;
                end
                k++;
            end else begin
                mem_ack = 1'b0; valid_i = 1'b0; MemWrite = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_ack = 1'b0; valid_i = 1'b0; MemWrite = 1'b0;
        o.lat = cyc + 1;
        o.req = k;
        o.rd  = ReadData;
        o.err = err_o;
        if (stall_o !== 1'b0) o.stallOk = 1'b0;
        @(posedge clk); #1;
        if (done_o !== 1'b0) o.pulseOk = 1'b0;
    endtask

    task automatic runAndCheck(input string tag, input vec_t v, input bit noise);
        obs_t o;
        int expReq;
        if (TRAP && isMis(v.f3, v.addr))       expReq = 0;
        else if (v.delay < 0 || v.delay >= TO) expReq = TO;
        else                                   expReq = v.delay + 1;
        applyStimulus(v, noise, o);
        checkOutput({tag, " latency"}, o.lat, v.expLat);
        checkOutput({tag, " err_o"}, {31'd0, o.err}, {31'd0, v.expErr});
        checkOutput({tag, " ReadData"}, o.rd, v.expRd);
        checkOutput({tag, " reqCycles"}, o.req, expReq);
        checkOutput({tag, " stall_o"}, {31'd0, o.stallOk}, 32'd1);
        checkOutput({tag, " donePulse"}, {31'd0, o.pulseOk}, 32'd1);
        if (expReq > 0) begin
            checkOutput({tag, " mem_addr"}, o.addr, v.expAddr);
            checkOutput({tag, " mem_be"}, {28'd0, o.be}, {28'd0, v.expBe});
            checkOutput({tag, " mem_we"}, {31'd0, o.we}, {31'd0, v.wr});
            checkOutput({tag, " reqStable"}, {31'd0, o.stable}, 32'd1);
            if (v.wr) checkOutput({tag, " mem_wdata"}, o.wdata, v.expWdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl[14];
        bit   doneSeen;
        logic        rw;
        logic [2:0]  f3;
        logic [31:0] rr;
        int          dly;
        logic [2:0]  storeF3[6];

        storeF3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
        tbl[0]  = mkVec(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 0, 2);
        tbl[1]  = mkVec(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0, 2);
        tbl[2]  = mkVec(1, 3'b000, 32'h103, 32'h000000AB, 32'h0, 0, 32'h100, 4'h8, 32'hABABABAB, 32'h0, 0, 2);
        tbl[3]  = mkVec(0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 32'h100, 4'hF, 32'h0, 32'hFFFFFF80, 0, 2);
        tbl[4]  = mkVec(0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 32'h100, 4'hF, 32'h0, 32'h00000080, 0, 2);
        tbl[5]  = mkVec(0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0, 32'h100, 4'hF, 32'h0, 32'hFFFF8001, 0, 2);
        tbl[6]  = mkVec(0, 3'b101, 32'h102, 32'h0, 32'h80011234, 0, 32'h100, 4'hF, 32'h0, 32'h00008001, 0, 2);
        tbl[7]  = mkVec(1, 3'b001, 32'h102, 32'hCAFE1234, 32'h0, 1, 32'h100, 4'hC, 32'h12341234, 32'h0, 0, 3);
        tbl[8]  = mkVec(0, 3'b010, 32'h200, 32'h0, 32'h12345678, 7, 32'h200, 4'hF, 32'h0, 32'h12345678, 0, 9);
        tbl[9]  = mkVec(0, 3'b010, 32'h300, 32'h0, 32'h55AA55AA, -1, 32'h300, 4'hF, 32'h0, 32'h0, 1, 9);
        tbl[10] = TRAP ? mkVec(0, 3'b010, 32'h102, 32'h0, 32'hA5A50001, 0, 32'h100, 4'hF, 32'h0, 32'h0, 1, 2)
                       : mkVec(0, 3'b010, 32'h102, 32'h0, 32'hA5A50001, 0, 32'h100, 4'hF, 32'h0, 32'hA5A50001, 0, 2);
        tbl[11] = mkVec(0, 3'b110, 32'h104, 32'h0, 32'h87654321, 2, 32'h104, 4'hF, 32'h0, 32'h87654321, 0, 4);
        tbl[12] = mkVec(1, 3'b000, 32'h101, 32'h123456C3, 32'h0, 0, 32'h100, 4'h2, 32'hC3C3C3C3, 32'h0, 0, 2);
        tbl[13] = mkVec(0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 32'h100, 4'hF, 32'h0, 32'h0000007F, 0, 2);

        reset = 1'b1; valid_i = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
        ALUResult = '0; WriteData = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset done_o", {31'd0, done_o}, 32'd0);
        checkOutput("reset err_o", {31'd0, err_o}, 32'd0);
        checkOutput("reset ReadData", ReadData, 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'd0);
        checkOutput("reset mem_be", {28'd0, mem_be}, 32'd0);
        checkOutput("reset stall_o", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) runAndCheck($sformatf("vec%0d", i), tbl[i], 1'b0);

        // Delayed ack with a second request presented mid-wait, which must be ignored
        runAndCheck("wait5", mkVec(0, 3'b010, 32'h400, 32'h0, 32'h0BADF00D, 5,
                                   32'h400, 4'hF, 32'h0, 32'h0BADF00D, 0, 7), 1'b1);

        // Reset while a request is outstanding
        @(negedge clk);
        valid_i = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h500;
        @(posedge clk); #1;
        valid_i = 1'b0; MemRead = 1'b0;
        checkOutput("rstmid mem_req before", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("rstmid mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rstmid stall_o", {31'd0, stall_o}, 32'd0);
        doneSeen = done_o;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            doneSeen = doneSeen | done_o;
        end
        checkOutput("rstmid no done", {31'd0, doneSeen}, 32'd0);
        runAndCheck("postrst", tbl[1], 1'b0);

        for (int i = 0; i < 80; i++) begin
            rw = 1'($urandom_range(0, 1));
            f3 = rw ? storeF3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            rr = $urandom_range(0, 15);
            dly = (rr < 12) ? int'(rr % 4) : (rr == 12) ? 7 : (rr == 13) ? -1 : 9;
            runAndCheck($sformatf("rnd%0d", i),
                        modelVec(rw, f3, $urandom, $urandom, $urandom, dly), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
